parking_exit_gate: RTL and testbench
====================================

# parking_exit_gate

Exit-side controller for the car park: the other direction of the entrance gate controller. It validates an exit payment code, opens and closes the exit barrier, and detects tailgating. It also keeps the lot occupancy count, incremented by entrance pulses and decremented by exits, and drives its own LEDs and a 2-digit 7-segment display.

## Interface
- CAPACITY, 15: maximum cars in the lot; legal range 1..255.
- TICKET_WAIT, 4: settle cycles before the payment code is sampled.
- OCC_W, $clog2(CAPACITY+1): occupancy width, derived.

- clk  in  1  rising-edge clock for all logic.
- reset  in  1  synchronous, active-high reset.
- sensor_exit_in  in  1  car present at the exit barrier (level).
- sensor_exit_out  in  1  car has passed the barrier (level).
- paid_code  in  2  payment code; 2'b11 = paid, any other value = unpaid.
- car_entered  in  1  one-cycle pulse from the entrance controller when a car enters.
- GREEN_LED  out  1  barrier open / blinking.
- RED_LED  out  1  waiting / error.
- HEX_1, HEX_2  out  7  active-low segments {g,f,e,d,c,b,a}.
- occupancy  out  OCC_W  cars currently in the lot.
- full  out  1  occupancy == CAPACITY (combinational from the register).

## Operation
- Moore FSM with states IDLE, WAIT_CODE, WRONG_CODE, OPEN, BLOCKED. Transitions are evaluated top-down; the first match wins.
- IDLE:
  - sensor_exit_in=1 and occupancy!=0 -> WAIT_CODE.
  - Otherwise stay.
- WAIT_CODE:
  - sensor_exit_in=0 -> IDLE.
  - wait_cnt==TICKET_WAIT and paid_code==2'b11 -> OPEN.
  - wait_cnt==TICKET_WAIT -> WRONG_CODE.
  - Otherwise stay.
- WRONG_CODE:
  - sensor_exit_in=0 -> IDLE.
  - paid_code==2'b11 -> OPEN.
  - Otherwise stay.
- OPEN:
  - sensor_exit_out=1 and sensor_exit_in=1 -> BLOCKED (tailgater). This counts one exit.
  - sensor_exit_out=1 -> IDLE. This counts one exit.
  - Otherwise stay.
- BLOCKED:
  - paid_code==2'b11 -> OPEN.
  - Otherwise stay.
- wait_cnt is a 32-bit counter. It increments every cycle in WAIT_CODE and is 0 in every other state.
- Occupancy:
  - +1 on car_entered when below CAPACITY; saturates at CAPACITY.
  - −1 on an exit event; saturates at 0.
  - car_entered together with an exit event in the same cycle leaves occupancy unchanged.
- Outputs per current_state, as {GREEN, RED, HEX_1, HEX_2}:
  - IDLE: {0, 0, 7'h7F, 7'h7F}.
  - WAIT_CODE: {0, 1, P=7'b0001100, d=7'b0100001}.
  - WRONG_CODE: {0, toggle, E=7'b0000110, E}.
  - OPEN: {toggle, 0, 6=7'b0000010, 0=7'b1000000}.
  - BLOCKED: {0, toggle, 5=7'b0010010, P}.
- "Toggle" means the LED register inverts its previous value every cycle.

## Timing
- State, wait_cnt, occupancy and the output registers all update on the rising edge of clk.
- LEDs and HEX are registered from current_state, so they lag the state by one cycle.
- WAIT_CODE lasts exactly TICKET_WAIT+1 cycles when the car stays. paid_code is sampled only in the last of those cycles.
- Withdrawal (sensor_exit_in=0) beats code evaluation in the same cycle.
- An exit event is counted once: OPEN is left in the same edge that decrements occupancy.
- Reset (synchronous) gives, on the next edge:
  - state IDLE;
  - wait_cnt 0;
  - occupancy 0;
  - GREEN_LED=0, RED_LED=0;
  - HEX_1=HEX_2=7'h7F.
- Reset mid-operation (for example in OPEN) discards the pending exit; no decrement occurs.
- Entering a toggle state takes the LED's prior value and inverts it. Example: RED goes 1 in WAIT_CODE, then 0 on the first WRONG_CODE output cycle.

## Configuration
- PARKING_EXIT_OCC_DISPLAY_EN defined:
  - In IDLE, HEX_1 shows occupancy[7:4] and HEX_2 shows occupancy[3:0] as active-low hex digits 0–F.
  - Bits above OCC_W read as 0.
- Not defined:
  - IDLE blanks both displays (7'h7F).
  - No hex-decode logic is built.

## Test plan
- Reset, then 3 car_entered pulses -> occupancy=3, full=0, outputs at reset values, HEX blank.
- occupancy=3; sensor_exit_in=1; paid_code=2'b11 held -> WAIT_CODE for 5 cycles, then OPEN with GREEN toggling and HEX=6/0.
  - Then sensor_exit_out=1 for one cycle -> IDLE, occupancy=2.
- paid_code=2'b00 at sample -> WRONG_CODE with RED alternating and HEX=E/E.
  - Then paid_code=2'b11 -> OPEN.
  - Alternatively drop sensor_exit_in -> IDLE, occupancy unchanged.
- In OPEN, sensor_exit_in=1 and sensor_exit_out=1 together -> BLOCKED (HEX=5/P), occupancy−1.
  - paid_code=2'b11 -> OPEN.
- CAPACITY=15 filled: full=1; extra car_entered ignored.
  - car_entered coincident with an exit event -> occupancy unchanged.
  - occupancy=0 with sensor_exit_in=1 -> stays IDLE.
- Synchronous reset asserted in WAIT_CODE -> IDLE and outputs cleared on the next edge.
  - With PARKING_EXIT_OCC_DISPLAY_EN and occupancy=0x0C: IDLE shows "0"/"C".

Source files
------------

// File: rtl/parking_exit_gate.sv
// rtl/parking_exit_gate.sv - exit barrier controller with occupancy count (option: PARKING_EXIT_OCC_DISPLAY_EN)
module parking_exit_gate #(
    parameter int CAPACITY    = 15,
    parameter int TICKET_WAIT = 4,
    parameter int OCC_W       = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sensor_exit_in,
    input  logic             sensor_exit_out,
    input  logic [1:0]       paid_code,
    input  logic             car_entered,
    output logic             GREEN_LED,
    output logic             RED_LED,
    output logic [6:0]       HEX_1,
    output logic [6:0]       HEX_2,
    output logic [OCC_W-1:0] occupancy,
    output logic             full
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CODE,
        S_WRONG_CODE,
        S_OPEN,
        S_BLOCKED
    } state_t;

    localparam logic [6:0]       SEG_BLANK = 7'h7F;
    localparam logic [6:0]       SEG_P     = 7'b0001100;
    localparam logic [6:0]       SEG_D     = 7'b0100001;
    localparam logic [6:0]       SEG_E     = 7'b0000110;
    localparam logic [6:0]       SEG_6     = 7'b0000010;
    localparam logic [6:0]       SEG_0     = 7'b1000000;
    localparam logic [6:0]       SEG_5     = 7'b0010010;
    localparam logic [31:0]      WAIT_LAST = 32'(TICKET_WAIT);
    localparam logic [OCC_W-1:0] OCC_MAX   = OCC_W'(CAPACITY);
    localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);

    state_t             state_q, state_d;
    logic [31:0]        wait_cnt_q, wait_cnt_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               green_q, green_d;
    logic               red_q, red_d;
    logic [6:0]         hex1_q, hex1_d;
    logic [6:0]         hex2_q, hex2_d;
    logic               paid_ok;
    logic               exit_event;

`ifdef PARKING_EXIT_OCC_DISPLAY_EN
    logic [7:0] occ_wide;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction
`endif

    assign paid_ok    = (paid_code == 2'b11);
    // Only a pass through the open barrier counts as an exit; leaving OPEN on the same edge keeps it single.
    assign exit_event = (state_q == S_OPEN) && sensor_exit_out;

    // Next state and settle counter; withdrawal is checked before the code.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (sensor_exit_in && (occ_q != '0)) state_d = S_WAIT_CODE;
            end
            S_WAIT_CODE: begin
                if (!sensor_exit_in)                      state_d = S_IDLE;
                else if ((wait_cnt_q == WAIT_LAST) && paid_ok) state_d = S_OPEN;
                else if (wait_cnt_q == WAIT_LAST)         state_d = S_WRONG_CODE;
            end
            S_WRONG_CODE: begin
                if (!sensor_exit_in) state_d = S_IDLE;
                else if (paid_ok)    state_d = S_OPEN;
            end
            S_OPEN: begin
                if (sensor_exit_out && sensor_exit_in) state_d = S_BLOCKED;
                else if (sensor_exit_out)              state_d = S_IDLE;
            end
            S_BLOCKED: begin
                if (paid_ok) state_d = S_OPEN;
            end
            default: state_d = S_IDLE;
        endcase
        wait_cnt_d = ((state_q == S_WAIT_CODE) && (state_d == S_WAIT_CODE)) ? wait_cnt_q + 32'd1 : 32'd0;
    end

    // Saturating occupancy; a simultaneous entry and exit cancel out.
    always_comb begin
        occ_d = occ_q;
        if (car_entered && exit_event)            occ_d = occ_q;
        else if (car_entered && occ_q != OCC_MAX) occ_d = occ_q + OCC_ONE;
        else if (exit_event && occ_q != '0)       occ_d = occ_q - OCC_ONE;
    end

    // LED and display values derived from the current state, toggling LEDs invert their last value.
    always_comb begin
        green_d = 1'b0;
        red_d   = 1'b0;
        hex1_d  = SEG_BLANK;
        hex2_d  = SEG_BLANK;
`ifdef PARKING_EXIT_OCC_DISPLAY_EN
        occ_wide = 8'(occ_q);
`endif
        case (state_q)
            S_IDLE: begin
`ifdef PARKING_EXIT_OCC_DISPLAY_EN
                hex1_d = hex7(occ_wide[7:4]);
                hex2_d = hex7(occ_wide[3:0]);
`else
                hex1_d = SEG_BLANK;
                hex2_d = SEG_BLANK;
`endif
            end
            S_WAIT_CODE: begin
                red_d  = 1'b1;
                hex1_d = SEG_P;
                hex2_d = SEG_D;
            end
            S_WRONG_CODE: begin
                red_d  = ~red_q;
                hex1_d = SEG_E;
                hex2_d = SEG_E;
            end
            S_OPEN: begin
                green_d = ~green_q;
                hex1_d  = SEG_6;
                hex2_d  = SEG_0;
            end
            S_BLOCKED: begin
                red_d  = ~red_q;
                hex1_d = SEG_5;
                hex2_d = SEG_P;
            end
            default: ;
        endcase
    end

    // All state, counters and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 32'd0;
            occ_q      <= '0;
            green_q    <= 1'b0;
            red_q      <= 1'b0;
            hex1_q     <= SEG_BLANK;
            hex2_q     <= SEG_BLANK;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            occ_q      <= occ_d;
            green_q    <= green_d;
            red_q      <= red_d;
            hex1_q     <= hex1_d;
            hex2_q     <= hex2_d;
        end
    end

    assign GREEN_LED = green_q;
    assign RED_LED   = red_q;
    assign HEX_1     = hex1_q;
    assign HEX_2     = hex2_q;
    assign occupancy = occ_q;
    assign full      = (occ_q == OCC_MAX);

endmodule

// File: tb/tb_parking_exit_gate.sv
// tb/tb_parking_exit_gate.sv - self-checking bench for parking_exit_gate
module tb_parking_exit_gate;

    localparam int CAP   = 15;
    localparam int TWAIT = 4;
    localparam int OW    = $clog2(CAP + 1);

    localparam int M_IDLE    = 0;
    localparam int M_WAIT    = 1;
    localparam int M_WRONG   = 2;
    localparam int M_OPEN    = 3;
    localparam int M_BLOCKED = 4;

    logic          clk = 1'b0;
    logic          rst, s_in, s_out, car;
    logic [1:0]    paid;
    logic          green, red, full;
    logic [6:0]    hex1, hex2;
    logic [OW-1:0] occ;

    int tests = 0;
    int fails = 0;

    int         m_mode, m_wait, m_occ;
    logic       m_g, m_r;
    logic [6:0] m_h1, m_h2;

    logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    parking_exit_gate #(.CAPACITY(CAP), .TICKET_WAIT(TWAIT)) dut (
        .clk            (clk),
        .reset          (rst),
        .sensor_exit_in (s_in),
        .sensor_exit_out(s_out),
        .paid_code      (paid),
        .car_entered    (car),
        .GREEN_LED      (green),
        .RED_LED        (red),
        .HEX_1          (hex1),
        .HEX_2          (hex2),
        .occupancy      (occ),
        .full           (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: apply one clock edge to the model using the inputs the DUT sees.
    task automatic model_edge();
        bit exit_now;
        if (rst) begin
            m_mode = M_IDLE; m_wait = 0; m_occ = 0;
            m_g = 1'b0; m_r = 1'b0; m_h1 = 7'h7F; m_h2 = 7'h7F;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_g = 0; m_r = 0;
`ifdef PARKING_EXIT_OCC_DISPLAY_EN
                    m_h1 = seg_tab[(m_occ / 16) % 16];
                    m_h2 = seg_tab[m_occ % 16];
`else
                    m_h1 = 7'h7F; m_h2 = 7'h7F;
`endif
                end
                M_WAIT:    begin m_g = 0;    m_r = 1;    m_h1 = 7'b0001100; m_h2 = 7'b0100001; end
                M_WRONG:   begin m_g = 0;    m_r = ~m_r; m_h1 = 7'b0000110; m_h2 = 7'b0000110; end
                M_OPEN:    begin m_g = ~m_g; m_r = 0;    m_h1 = 7'b0000010; m_h2 = 7'b1000000; end
                default:   begin m_g = 0;    m_r = ~m_r; m_h1 = 7'b0010010; m_h2 = 7'b0001100; end
            endcase
            exit_now = (m_mode == M_OPEN) && s_out;
            if (car && exit_now) m_occ = m_occ;
            else if (car)        m_occ = (m_occ < CAP) ? m_occ + 1 : CAP;
            else if (exit_now)   m_occ = (m_occ > 0) ? m_occ - 1 : 0;
            case (m_mode)
                M_IDLE: if (s_in && m_occ_before_nonzero(exit_now)) begin m_mode = M_WAIT; m_wait = 0; end
                M_WAIT: begin
                    if (!s_in)                             begin m_mode = M_IDLE; m_wait = 0; end
                    else if (m_wait == TWAIT)              begin m_mode = (paid == 2'b11) ? M_OPEN : M_WRONG; m_wait = 0; end
                    else                                   m_wait++;
                end
                M_WRONG: begin
                    if (!s_in)              m_mode = M_IDLE;
                    else if (paid == 2'b11) m_mode = M_OPEN;
                end
                M_OPEN: begin
                    if (s_out && s_in) m_mode = M_BLOCKED;
                    else if (s_out)    m_mode = M_IDLE;
                end
                default: if (paid == 2'b11) m_mode = M_OPEN;
            endcase
        end
    endtask

    // IDLE leaves only when the lot held a car before this edge.
    int occ_prev;
    function automatic bit m_occ_before_nonzero(input bit unused_exit);
        return (occ_prev != 0) || unused_exit;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            occ_prev = m_occ;
            model_edge();
            #1;
            check("green", 32'(green), 32'(m_g));
            check("red",   32'(red),   32'(m_r));
            check("hex1",  32'(hex1),  32'(m_h1));
            check("hex2",  32'(hex2),  32'(m_h2));
            check("occ",   32'(occ),   32'(m_occ));
            check("full",  32'(full),  32'(m_occ == CAP));
        end
    endtask

    initial begin
        rst = 1; s_in = 0; s_out = 0; car = 0; paid = 2'b00;
        m_mode = M_IDLE; m_wait = 0; m_occ = 0; occ_prev = 0;
        m_g = 0; m_r = 0; m_h1 = 7'h7F; m_h2 = 7'h7F;
        step(2);
        check("rst_occ", 32'(occ), 32'd0);
        check("rst_hex1", 32'(hex1), 32'h7F);
        rst = 0;

        // Three entries.
        repeat (3) begin car = 1; step(1); car = 0; step(1); end
        check("occ_3", 32'(occ), 32'd3);
        check("full_3", 32'(full), 32'd0);

        // Paid exit.
        s_in = 1; paid = 2'b11;
        step(7);
        check("open_hex1", 32'(hex1), 32'(7'b0000010));
        check("open_hex2", 32'(hex2), 32'(7'b1000000));
        check("open_green", 32'(green), 32'd1);
        step(2);
        s_in = 0; s_out = 1; step(1);
        s_out = 0; step(2);
        check("occ_2", 32'(occ), 32'd2);

        // Wrong code, then pay.
        s_in = 1; paid = 2'b00; step(9);
        check("wrong_hex1", 32'(hex1), 32'(7'b0000110));
        paid = 2'b11; step(3);
        s_in = 0; s_out = 1; step(1); s_out = 0; step(1);

        // Wrong code, then withdraw.
        s_in = 1; paid = 2'b01; step(8);
        s_in = 0; step(3);
        check("occ_withdraw", 32'(occ), 32'd1);

        // Tailgater.
        s_in = 1; paid = 2'b11; step(7);
        paid = 2'b00; s_out = 1; step(1); s_out = 0; step(3);
        check("blocked_hex1", 32'(hex1), 32'(7'b0010010));
        check("blocked_occ", 32'(occ), 32'd0);
        paid = 2'b11; step(2);
        s_in = 0; paid = 2'b00; step(2);

        // Empty lot: car at exit must not start a transaction.
        rst = 1; step(1); rst = 0;
        s_in = 1; step(4);
        check("empty_idle_red", 32'(red), 32'd0);
        s_in = 0;

        // Fill beyond capacity, then coincident entry/exit.
        car = 1; step(18); car = 0; step(1);
        check("full_set", 32'(full), 32'd1);
        check("occ_cap", 32'(occ), 32'(CAP));
        s_in = 1; paid = 2'b11; step(7);
        s_in = 0; s_out = 1; car = 1; step(1);
        s_out = 0; car = 0; step(1);
        check("occ_coincident", 32'(occ), 32'(CAP));

        // Reset during WAIT_CODE.
        s_in = 1; step(3);
        rst = 1; step(1);
        check("rst_wait_red", 32'(red), 32'd0);
        check("rst_wait_hex2", 32'(hex2), 32'h7F);
        rst = 0; s_in = 0;

        // Twelve cars then idle display.
        car = 1; step(12); car = 0; step(2);
`ifdef PARKING_EXIT_OCC_DISPLAY_EN
        check("disp_c", 32'(hex2), 32'(7'b1000110));
`else
        check("disp_blank", 32'(hex2), 32'h7F);
`endif

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            s_in  = ($urandom_range(0, 3) != 0);
            s_out = ($urandom_range(0, 4) == 0);
            car   = ($urandom_range(0, 3) == 0);
            paid  = 2'($urandom_range(0, 3));
            step(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
